mem_stage: RTL and testbench

Memory-access pipeline stage between EX and WB. Holds one instruction and waits for the data-SRAM response of any load/store EX issued. Aligns and sign/zero-extends load data, then presents the 211-bit `mem_to_wb_bus` to WB with a valid/allowin handshake. Cancels in-flight responses when WB flushes the pipeline, and publishes forwarding/hazard info to ID and EX.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 31 +++
 rtl/load_align.sv | 29 ++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, load-op encodings,
// stage state encoding and the layout of the EX->MEM bus.
package cpu_pkg;

  localparam int TAIL_W   = 173;
  localparam int EXC_IDX  = 140;
  localparam int ERTN_IDX = 141;

  localparam int EX_MEM_W = 44 + TAIL_W;
  localparam int MEM_WB_W = 211;
  localparam int MEM_ID_W = 39;

  // One-hot load opcodes, ordered {b, bu, h, hu, w}
  localparam logic [4:0] LD_OP_B  = 5'b10000;
  localparam logic [4:0] LD_OP_BU = 5'b01000;
  localparam logic [4:0] LD_OP_H  = 5'b00100;
  localparam logic [4:0] LD_OP_HU = 5'b00010;
  localparam logic [4:0] LD_OP_W  = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_st_t;

  typedef struct packed {
    logic [4:0]        ld_op;
    logic              mem_req;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       result;
    logic [TAIL_W-1:0] tail;
  } ex_mem_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data buses around the MEM stage. The master modport is the
// stage itself; the slave modport is the surrounding pipeline (EX, WB, SRAM).
interface mem_stage_if;

  logic                          ex_to_mem_valid;
  logic                          mem_allowin;
  cpu_pkg::ex_mem_bus_t          ex_to_mem_bus;
  logic                          data_sram_data_ok;
  logic [31:0]                   data_sram_rdata;
  logic                          wb_allowin;
  logic                          mem_to_wb_valid;
  logic [cpu_pkg::MEM_WB_W-1:0]  mem_to_wb_bus;
  logic                          wb_ex;
  logic                          ertn_flush;
  logic                          wb_refetch_flush;
  logic [cpu_pkg::MEM_ID_W-1:0]  mem_to_id_bus;
  logic                          mem_to_ex_bus;

  modport master (
    input  ex_to_mem_valid, ex_to_mem_bus, data_sram_data_ok, data_sram_rdata,
           wb_allowin, wb_ex, ertn_flush, wb_refetch_flush,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus, mem_to_ex_bus
  );

  modport slave (
    output ex_to_mem_valid, ex_to_mem_bus, data_sram_data_ok, data_sram_rdata,
           wb_allowin, wb_ex, ertn_flush, wb_refetch_flush,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus, mem_to_ex_bus
  );

endinterface

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends according to the one-hot load opcode.
module load_align
  import cpu_pkg::*;
(
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] wdata_o
);

  logic [31:0] shifted_s;

  assign shifted_s = word_i >> {off_i, 3'b000};

  // Select extension mode from the load opcode
  always_comb begin
    wdata_o = word_i;
    case (ld_op_i)
      LD_OP_B:  wdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LD_OP_BU: wdata_o = {24'h000000, shifted_s[7:0]};
      LD_OP_H:  wdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LD_OP_HU: wdata_o = {16'h0000, shifted_s[15:0]};
      LD_OP_W:  wdata_o = word_i;
      default:  wdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// aligns load data and hands the result to WB. A flush while a request is
// outstanding arms 'cancel' so the orphaned response is swallowed later.
module mem_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  mem_stage_if.master  io
);

  ex_mem_bus_t bus_q, bus_d;
  logic        mem_valid_q, mem_valid_d;
  mem_st_t     st_q, st_d;
  logic        cancel_q, cancel_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        flush_s;
  logic        pending_s;
  logic        resp_hit_s;
  logic        ready_go_s;
  logic        allowin_s;
  logic        accept_s;
  logic        retire_s;
  logic        is_load_s;
  logic [31:0] word_s;
  logic [31:0] aligned_s;
  logic [31:0] rf_wdata_s;
  logic [31:0] fwd_wdata_s;
  logic        fwd_we_s;
  logic        ld_stall_s;

  assign flush_s    = io.wb_ex | io.ertn_flush | io.wb_refetch_flush;
  assign pending_s  = mem_valid_q & (st_q == WAIT);
  // A response only belongs to us when no cancelled request is still in flight
  assign resp_hit_s = pending_s & io.data_sram_data_ok & ~cancel_q;
  assign ready_go_s = ~bus_q.mem_req | resp_hit_s | (st_q == HOLD);
  assign allowin_s  = ~mem_valid_q | (ready_go_s & io.wb_allowin);
  assign accept_s   = io.ex_to_mem_valid & allowin_s & ~flush_s;
  assign retire_s   = mem_valid_q & ready_go_s & io.wb_allowin;
  assign is_load_s  = (bus_q.ld_op != 5'b00000);

  // Captured data must be used in HOLD, the live SRAM bus otherwise
  assign word_s = (st_q == HOLD) ? rdata_buf_q : io.data_sram_rdata;

  load_align u_load_align (
    .ld_op_i (bus_q.ld_op),
    .off_i   (bus_q.result[1:0]),
    .word_i  (word_s),
    .wdata_o (aligned_s)
  );

  assign rf_wdata_s  = is_load_s ? aligned_s : bus_q.result;
  assign fwd_wdata_s = (is_load_s & ~ready_go_s) ? bus_q.result : rf_wdata_s;
  assign fwd_we_s    = mem_valid_q & bus_q.rf_we & ~bus_q.tail[EXC_IDX];
  assign ld_stall_s  = mem_valid_q & is_load_s & ~ready_go_s;

  assign io.mem_allowin     = allowin_s;
  assign io.mem_to_wb_valid = mem_valid_q & ready_go_s & ~flush_s;
  assign io.mem_to_wb_bus   = {bus_q.rf_we, bus_q.rf_waddr, rf_wdata_s, bus_q.tail};
  assign io.mem_to_id_bus   = {fwd_we_s, bus_q.rf_waddr, fwd_wdata_s, ld_stall_s};
  assign io.mem_to_ex_bus   = mem_valid_q & (bus_q.tail[EXC_IDX] | bus_q.tail[ERTN_IDX]);

  // Next-state: occupancy, wait/hold sequencing and response buffering
  always_comb begin
    mem_valid_d = mem_valid_q;
    st_d        = st_q;
    rdata_buf_d = rdata_buf_q;
    bus_d       = bus_q;
    if (flush_s) begin
      mem_valid_d = 1'b0;
      st_d        = IDLE;
    end else if (accept_s) begin
      mem_valid_d = 1'b1;
      bus_d       = io.ex_to_mem_bus;
      st_d        = io.ex_to_mem_bus.mem_req ? WAIT : IDLE;
    end else if (retire_s) begin
      mem_valid_d = 1'b0;
      st_d        = IDLE;
    end else if (resp_hit_s) begin
      rdata_buf_d = io.data_sram_rdata;
      st_d        = HOLD;
    end else begin
      st_d        = st_q;
    end
  end

  // Next-state: cancel tracks one orphaned request left behind by a flush
  always_comb begin
    cancel_d = cancel_q;
    if (cancel_q) begin
      if (io.data_sram_data_ok) begin
        // The orphan is consumed; re-arm only if a newer request is also flushed
        cancel_d = flush_s & pending_s;
      end else begin
        cancel_d = 1'b1;
      end
    end else if (flush_s & pending_s & ~io.data_sram_data_ok) begin
      cancel_d = 1'b1;
    end else begin
      cancel_d = 1'b0;
    end
  end

  // Stage state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      st_q        <= IDLE;
      cancel_q    <= 1'b0;
      rdata_buf_q <= 32'h0000_0000;
      bus_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      st_q        <= st_d;
      cancel_q    <= cancel_d;
      rdata_buf_q <= rdata_buf_d;
      bus_q       <= bus_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors plus
// hand-written sequences for hold, flush/cancel, forwarding and reset cases.
module tb_mem_stage;
  import cpu_pkg::*;

  logic clk;
  logic resetn;

  mem_stage_if bif ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int outst    = 0;

  typedef struct {
    logic [4:0]  op;
    logic        req;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // advance to the drive point of the next cycle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.ex_to_mem_valid   = 1'b0;
    bif.data_sram_data_ok = 1'b0;
    bif.data_sram_rdata   = 32'h0000_0000;
    bif.wb_allowin        = 1'b1;
    bif.wb_ex             = 1'b0;
    bif.ertn_flush        = 1'b0;
    bif.wb_refetch_flush  = 1'b0;
  endtask

  function automatic ex_mem_bus_t mk(input logic [4:0] op, input logic req, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res,
                                     input logic [TAIL_W-1:0] tl);
    ex_mem_bus_t b;
    b.ld_op    = op;
    b.mem_req  = req;
    b.rf_we    = we;
    b.rf_waddr = wa;
    b.result   = res;
    b.tail     = tl;
    return b;
  endfunction

  task automatic issue(input ex_mem_bus_t b);
    bif.ex_to_mem_valid = 1'b1;
    bif.ex_to_mem_bus   = b;
    if (b.mem_req) outst++;
  endtask

  task automatic resp(input logic [31:0] d);
    chk("dok_legal", {63'd0, (outst > 0)}, 64'd1);
    bif.data_sram_data_ok = 1'b1;
    bif.data_sram_rdata   = d;
    if (outst > 0) outst--;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [TAIL_W-1:0] tl;
    logic [TAIL_W-1:0] zt;
    zt = '0;
    tl = '0;

    vt[0]  = '{LD_OP_B,  1'b1, 32'h0000_2003, 32'h80FF_0000, 32'hFFFF_FF80};
    vt[1]  = '{LD_OP_BU, 1'b1, 32'h0000_2003, 32'h80FF_0000, 32'h0000_0080};
    vt[2]  = '{LD_OP_B,  1'b1, 32'h0000_2000, 32'h1234_567F, 32'h0000_007F};
    vt[3]  = '{LD_OP_BU, 1'b1, 32'h0000_2001, 32'h0000_AB00, 32'h0000_00AB};
    vt[4]  = '{LD_OP_H,  1'b1, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001};
    vt[5]  = '{LD_OP_HU, 1'b1, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001};
    vt[6]  = '{LD_OP_H,  1'b1, 32'h0000_2000, 32'h0000_7FFE, 32'h0000_7FFE};
    vt[7]  = '{LD_OP_W,  1'b1, 32'h0000_2000, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vt[8]  = '{LD_OP_B,  1'b1, 32'h0000_2002, 32'h0081_0000, 32'hFFFF_FF81};
    vt[9]  = '{LD_OP_HU, 1'b1, 32'h0000_2000, 32'h1234_F00D, 32'h0000_F00D};
    vt[10] = '{5'b00000, 1'b0, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0011};
    vt[11] = '{5'b00000, 1'b1, 32'h1000_0004, 32'hFFFF_FFFF, 32'h1000_0004};

    // reset state
    resetn = 1'b0;
    idle_inputs();
    bif.ex_to_mem_bus = mk(5'b00000, 1'b0, 1'b0, 5'd0, 32'h0, zt);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", {63'd0, bif.mem_allowin}, 64'd1);
    chk("rst_wb_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    chk("rst_id_bus", {25'd0, bif.mem_to_id_bus}, 64'd0);
    chk("rst_ex_bus", {63'd0, bif.mem_to_ex_bus}, 64'd0);
    cyc();
    resetn = 1'b1;
    cyc();

    // table: accept, then response (if any) in the following cycle
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      tl = {{(TAIL_W-32){1'b0}}, 32'hA5A5_0000 | 32'(i)};
      issue(mk(vt[i].op, vt[i].req, 1'b1, 5'd3, vt[i].res, tl));
      @(negedge clk);
      chk($sformatf("vec%0d_allowin", i), {63'd0, bif.mem_allowin}, 64'd1);
      cyc();
      bif.ex_to_mem_valid = 1'b0;
      if (vt[i].req) resp(vt[i].rdata);
      else bif.data_sram_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'd0, bif.mem_to_wb_valid}, 64'd1);
      chk($sformatf("vec%0d_wdata", i), {32'd0, bif.mem_to_wb_bus[204:173]}, {32'd0, vt[i].exp});
      chk($sformatf("vec%0d_waddr", i), {59'd0, bif.mem_to_wb_bus[209:205]}, 64'd3);
      chk($sformatf("vec%0d_tail", i), {63'd0, (bif.mem_to_wb_bus[172:0] == tl)}, 64'd1);
      cyc();
    end
    idle_inputs();

    // ld.b off 3, data_ok two cycles after accept
    issue(mk(LD_OP_B, 1'b1, 1'b1, 5'd7, 32'h0000_1003, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("s1_wait_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    chk("s1_wait_stall", {63'd0, bif.mem_to_id_bus[0]}, 64'd1);
    chk("s1_wait_allowin", {63'd0, bif.mem_allowin}, 64'd0);
    cyc();
    resp(32'h80FF_0000);
    @(negedge clk);
    chk("s1_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s1_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'hFFFF_FF80);
    chk("s1_fwd_wdata", {32'd0, bif.mem_to_id_bus[32:1]}, 64'hFFFF_FF80);
    chk("s1_stall_off", {63'd0, bif.mem_to_id_bus[0]}, 64'd0);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("s1_after", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    cyc();

    // ld.hu off 2 with WB stalled: HOLD keeps captured data
    issue(mk(LD_OP_HU, 1'b1, 1'b1, 5'd9, 32'h0000_3002, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    bif.wb_allowin = 1'b0;
    resp(32'h8001_1234);
    @(negedge clk);
    chk("s2_dok_allowin", {63'd0, bif.mem_allowin}, 64'd0);
    chk("s2_dok_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h0000_8001);
    for (int k = 0; k < 3; k++) begin
      cyc();
      bif.data_sram_data_ok = 1'b0;
      bif.data_sram_rdata   = 32'hFFFF_FFFF;
      @(negedge clk);
      chk($sformatf("s2_hold%0d_stall", k), {63'd0, bif.mem_to_id_bus[0]}, 64'd0);
      chk($sformatf("s2_hold%0d_allowin", k), {63'd0, bif.mem_allowin}, 64'd0);
      chk($sformatf("s2_hold%0d_wdata", k), {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h0000_8001);
    end
    cyc();
    bif.wb_allowin = 1'b1;
    @(negedge clk);
    chk("s2_retire_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s2_retire_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h0000_8001);
    chk("s2_retire_allowin", {63'd0, bif.mem_allowin}, 64'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("s2_after", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    cyc();

    // flush while waiting, then stale and fresh responses
    issue(mk(LD_OP_W, 1'b1, 1'b1, 5'd4, 32'h0000_4000, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    bif.wb_ex = 1'b1;
    @(negedge clk);
    chk("s3_flush_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    cyc();
    bif.wb_ex = 1'b0;
    issue(mk(LD_OP_W, 1'b1, 1'b1, 5'd4, 32'h0000_4004, zt));
    @(negedge clk);
    chk("s3_new_allowin", {63'd0, bif.mem_allowin}, 64'd1);
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    resp(32'hDEAD_BEEF);
    @(negedge clk);
    chk("s3_stale_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    chk("s3_stale_stall", {63'd0, bif.mem_to_id_bus[0]}, 64'd1);
    cyc();
    resp(32'h1234_5678);
    @(negedge clk);
    chk("s3_fresh_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s3_fresh_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h1234_5678);
    cyc();
    idle_inputs();

    // ertn_flush together with data_ok, with an accept attempt in that cycle
    issue(mk(LD_OP_W, 1'b1, 1'b1, 5'd6, 32'h0000_5000, zt));
    cyc();
    issue(mk(5'b00000, 1'b0, 1'b1, 5'd6, 32'h0000_0BAD, zt));
    bif.ertn_flush = 1'b1;
    resp(32'h0000_0055);
    @(negedge clk);
    chk("s4_flush_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("s4_no_accept", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    issue(mk(LD_OP_W, 1'b1, 1'b1, 5'd6, 32'h0000_5004, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    resp(32'h0000_600D);
    @(negedge clk);
    chk("s4_next_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s4_next_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h0000_600D);
    cyc();
    idle_inputs();

    // back-to-back ALU ops to r5 with forwarding
    issue(mk(5'b00000, 1'b0, 1'b1, 5'd5, 32'h0000_0011, zt));
    cyc();
    issue(mk(5'b00000, 1'b0, 1'b1, 5'd5, 32'h0000_0022, zt));
    @(negedge clk);
    chk("s5_a_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s5_a_allowin", {63'd0, bif.mem_allowin}, 64'd1);
    chk("s5_a_id", {25'd0, bif.mem_to_id_bus}, {25'd0, 1'b1, 5'd5, 32'h0000_0011, 1'b0});
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("s5_b_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s5_b_id", {25'd0, bif.mem_to_id_bus}, {25'd0, 1'b1, 5'd5, 32'h0000_0022, 1'b0});
    cyc();
    @(negedge clk);
    chk("s5_after", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    cyc();

    // exception tail suppresses forwarding; ertn tail only raises mem_to_ex
    tl = '0;
    tl[EXC_IDX] = 1'b1;
    issue(mk(5'b00000, 1'b0, 1'b1, 5'd8, 32'h0000_0077, tl));
    cyc();
    tl = '0;
    tl[ERTN_IDX] = 1'b1;
    issue(mk(5'b00000, 1'b0, 1'b1, 5'd8, 32'h0000_0078, tl));
    @(negedge clk);
    chk("s6_exc_fwd_we", {63'd0, bif.mem_to_id_bus[38]}, 64'd0);
    chk("s6_exc_ex_bus", {63'd0, bif.mem_to_ex_bus}, 64'd1);
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("s6_ertn_fwd_we", {63'd0, bif.mem_to_id_bus[38]}, 64'd1);
    chk("s6_ertn_ex_bus", {63'd0, bif.mem_to_ex_bus}, 64'd1);
    cyc();
    @(negedge clk);
    chk("s6_idle_ex_bus", {63'd0, bif.mem_to_ex_bus}, 64'd0);
    cyc();

    // reset in the middle of WAIT (SRAM is reset too)
    issue(mk(LD_OP_W, 1'b1, 1'b1, 5'd2, 32'h0000_6000, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    resetn = 1'b0;
    outst = 0;
    @(negedge clk);
    chk("s7_rst_allowin", {63'd0, bif.mem_allowin}, 64'd1);
    chk("s7_rst_valid", {63'd0, bif.mem_to_wb_valid}, 64'd0);
    chk("s7_rst_id", {25'd0, bif.mem_to_id_bus}, 64'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    issue(mk(LD_OP_BU, 1'b1, 1'b1, 5'd2, 32'h0000_6001, zt));
    cyc();
    bif.ex_to_mem_valid = 1'b0;
    resp(32'h0000_C300);
    @(negedge clk);
    chk("s7_post_valid", {63'd0, bif.mem_to_wb_valid}, 64'd1);
    chk("s7_post_wdata", {32'd0, bif.mem_to_wb_bus[204:173]}, 64'h0000_00C3);
    cyc();
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
